// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the RV32 core's data port to a handshaked word RAM.
// Decodes lanes, checks legality, stalls the core and extends load data.
module lsu_mem_bridge #(
  parameter logic [31:0] DBASE   = 32'h1001_0000,
  parameter logic [31:0] DSIZE   = 32'h0001_0000,
  parameter int          TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic          mreq_q, mreq_d;
  logic          mwe_q, mwe_d;
  logic [3:0]    mbe_q, mbe_d;
  logic [29:0]   maddr_q, maddr_d;
  logic [31:0]   mwd_q, mwd_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;

  logic [31:0] offset;
  logic [1:0]  sz, o;
  logic        legal;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  // Unsigned offset compare never wraps, even when the window ends at 2^32.
  assign offset = req_addr - DBASE;
  assign sz     = req_funct3[1:0];
  assign o      = req_addr[1:0];
  assign legal  = (sz != 2'b11)
                & ~(req_funct3[2] & sz[1])
                & ~(req_we & req_funct3[2])
                & ~((sz == 2'b01) & o[0])
                & ~((sz == 2'b10) & (o != 2'b00))
                & (offset < DSIZE);

  always_comb begin
    be_c = 4'b1111;
    wd_c = req_wdata;
    unique case (1'b1)
      (sz == 2'b00): begin
        be_c = 4'b0001 << o;
        wd_c = {4{req_wdata[7:0]}};
      end
      (sz == 2'b01): begin
        be_c = o[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_b = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_ext = mem_rdata;
    unique case (1'b1)
      (f3_q == 3'b000): ld_ext = {{24{ld_b[7]}}, ld_b};
      (f3_q == 3'b100): ld_ext = {24'h0, ld_b};
      (f3_q == 3'b001): ld_ext = {{16{ld_h[15]}}, ld_h};
      (f3_q == 3'b101): ld_ext = {16'h0, ld_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    mreq_d  = mreq_q;
    mwe_d   = mwe_q;
    mbe_d   = mbe_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && legal) begin
          state_d = S_REQ;
          cnt_d   = '0;
          mreq_d  = 1'b1;
          mwe_d   = req_we;
          mbe_d   = be_c;
          maddr_d = offset[31:2];
          mwd_d   = wd_c;
          f3_d    = req_funct3;
          off_d   = o;
        end else if (req_valid) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          rdata_d = POISON;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_DONE;
          mreq_d  = 1'b0;
          rdata_d = ld_ext;
          fault_d = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d = S_DONE;
          mreq_d  = 1'b0;
          rdata_d = POISON;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= POISON;
      fault_q <= 1'b0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      mbe_q   <= 4'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      mbe_q   <= mbe_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign stall     = req_valid & (state_q != S_DONE);
  assign rdata     = rdata_q;
  assign fault     = fault_q;
  assign mem_req   = mreq_q;
  assign mem_we    = mwe_q;
  assign mem_be    = mbe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwd_q;

endmodule
